// File: rtl/t_l.sv
// Thunderbird-style tail-light sequencer: three lamps per side, outward turn sweeps, hazard flash.
// Optional T_L_SYNC_IN_EN adds 2-flop synchronizers on the L/R/H request inputs.
module t_l #(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       L,
  input  logic       R,
  input  logic       H,
  output logic [2:0] TL,
  output logic [2:0] TR
);

  localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    LR3  = 3'd7
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          l_s, r_s, h_s;

`ifdef T_L_SYNC_IN_EN
  logic [1:0] l_sync, r_sync, h_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_sync <= '0;
      r_sync <= '0;
      h_sync <= '0;
    end else begin
      l_sync <= {l_sync[0], L};
      r_sync <= {r_sync[0], R};
      h_sync <= {h_sync[0], H};
    end
  end

  assign l_s = l_sync[1];
  assign r_s = r_sync[1];
  assign h_s = h_sync[1];
`else
  assign l_s = L;
  assign r_s = R;
  assign h_s = H;
`endif

  // With STEP_CYCLES=1 the counter sits at 0 and every edge is a tick.
  assign tick = (cnt == CW'(STEP_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    TL       = '0;
    TR       = '0;

    if (tick) begin
      unique case (state)
        IDLE: begin
          if (h_s || (l_s && r_s)) state_nx = LR3;
          else if (l_s)            state_nx = L1;
          else if (r_s)            state_nx = R1;
          else                     state_nx = IDLE;
        end
        L1:      state_nx = h_s ? LR3 : L2;
        L2:      state_nx = h_s ? LR3 : L3;
        R1:      state_nx = h_s ? LR3 : R2;
        R2:      state_nx = h_s ? LR3 : R3;
        L3, R3, LR3: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end

    unique case (state)
      IDLE:    begin TL = 3'b000; TR = 3'b000; end
      L1:      begin TL = 3'b001; TR = 3'b000; end
      L2:      begin TL = 3'b011; TR = 3'b000; end
      L3:      begin TL = 3'b111; TR = 3'b000; end
      R1:      begin TL = 3'b000; TR = 3'b001; end
      R2:      begin TL = 3'b000; TR = 3'b011; end
      R3:      begin TL = 3'b000; TR = 3'b111; end
      LR3:     begin TL = 3'b111; TR = 3'b111; end
      default: begin TL = 3'b000; TR = 3'b000; end
    endcase
  end

endmodule

// File: tb/tb_t_l.sv
// Directed scoreboard bench for t_l: a unit with STEP_CYCLES=1 and a second with STEP_CYCLES=3.
module tb_t_l;

`ifdef T_L_SYNC_IN_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       l = 1'b0, r = 1'b0, h = 1'b0;
  logic [2:0] tl, tr;

  logic       rst3 = 1'b1;
  logic       l3 = 1'b0;
  logic [2:0] tl3, tr3;

  logic [5:0] q[$];
  logic [5:0] q3[$];
  int unsigned vecs = 0;
  int unsigned errs = 0;

  t_l u1 (
    .clk(clk), .rst(rst), .L(l), .R(r), .H(h), .TL(tl), .TR(tr)
  );

  t_l #(.STEP_CYCLES(3)) u3 (
    .clk(clk), .rst(rst3), .L(l3), .R(1'b0), .H(1'b0), .TL(tl3), .TR(tr3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] act, input logic [5:0] exp);
    vecs++;
    assert (act === exp) else begin
      errs++;
      $error("FAIL %s: observed TL/TR=%b/%b expected %b/%b", tag, act[5:3], act[2:0], exp[5:3], exp[2:0]);
    end
  endtask

  task automatic prefill();
    for (int unsigned i = 0; i < LAT; i++) q.push_back(6'b000_000);
  endtask

  // Entered and left on a falling edge: drive, expect, clock, compare.
  task automatic step(input string tag, input logic li, input logic ri, input logic hi,
                      input logic [2:0] etl, input logic [2:0] etr);
    logic [5:0] exp;
    l = li; r = ri; h = hi;
    q.push_back({etl, etr});
    @(posedge clk);
    #1;
    exp = q.pop_front();
    chk(tag, {tl, tr}, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] e3;

    repeat (3) @(negedge clk);
    chk("reset_state", {tl, tr}, 6'b000_000);
    chk("reset_state_u3", {tl3, tr3}, 6'b000_000);

    // 1: left sweep held, released from reset with L high
    rst = 1'b0;
    prefill();
    step("left_a", 1, 0, 0, 3'b001, 3'b000);
    step("left_b", 1, 0, 0, 3'b011, 3'b000);
    step("left_c", 1, 0, 0, 3'b111, 3'b000);
    step("left_d", 1, 0, 0, 3'b000, 3'b000);
    step("left_e", 1, 0, 0, 3'b001, 3'b000);
    step("left_f", 1, 0, 0, 3'b011, 3'b000);
    step("left_g", 1, 0, 0, 3'b111, 3'b000);
    step("left_h", 0, 0, 0, 3'b000, 3'b000);
    step("idle_a", 0, 0, 0, 3'b000, 3'b000);

    // 2: right sweep
    step("right_a", 0, 1, 0, 3'b000, 3'b001);
    step("right_b", 0, 1, 0, 3'b000, 3'b011);
    step("right_c", 0, 1, 0, 3'b000, 3'b111);
    step("right_d", 0, 0, 0, 3'b000, 3'b000);
    step("idle_b",  0, 0, 0, 3'b000, 3'b000);

    // 3: hazard with a turn request, then hazard preempting L2
    step("haz_a", 1, 0, 1, 3'b111, 3'b111);
    step("haz_b", 1, 0, 1, 3'b000, 3'b000);
    step("haz_c", 0, 1, 1, 3'b111, 3'b111);
    step("haz_d", 0, 1, 1, 3'b000, 3'b000);
    step("haz_e", 0, 0, 0, 3'b000, 3'b000);
    step("pre_a", 1, 0, 0, 3'b001, 3'b000);
    step("pre_b", 1, 0, 0, 3'b011, 3'b000);
    step("pre_c", 0, 0, 1, 3'b111, 3'b111);
    step("pre_d", 0, 0, 0, 3'b000, 3'b000);
    step("pre_e", 0, 0, 0, 3'b000, 3'b000);

    // 4: L&R behaves as hazard; one-cycle L pulse completes a sweep
    step("lr_a", 1, 1, 0, 3'b111, 3'b111);
    step("lr_b", 1, 1, 0, 3'b000, 3'b000);
    step("lr_c", 1, 1, 0, 3'b111, 3'b111);
    step("lr_d", 0, 0, 0, 3'b000, 3'b000);
    step("pulse_a", 1, 0, 0, 3'b001, 3'b000);
    step("pulse_b", 0, 0, 0, 3'b011, 3'b000);
    step("pulse_c", 0, 0, 0, 3'b111, 3'b000);
    step("pulse_d", 0, 0, 0, 3'b000, 3'b000);
    step("pulse_e", 0, 0, 0, 3'b000, 3'b000);

    // direction change mid-sweep waits for IDLE
    step("dir_a", 1, 0, 0, 3'b001, 3'b000);
    step("dir_b", 0, 1, 0, 3'b011, 3'b000);
    step("dir_c", 0, 1, 0, 3'b111, 3'b000);
    step("dir_d", 0, 1, 0, 3'b000, 3'b000);
    step("dir_e", 0, 1, 0, 3'b000, 3'b001);
    step("dir_f", 0, 0, 0, 3'b000, 3'b011);
    step("dir_g", 0, 0, 0, 3'b000, 3'b111);
    step("dir_h", 0, 0, 0, 3'b000, 3'b000);

    // 5: asynchronous reset mid-sweep, then restart from L1
    step("ar_a", 1, 0, 0, 3'b001, 3'b000);
    step("ar_b", 1, 0, 0, 3'b011, 3'b000);
    #2 rst = 1'b1;
    #1 chk("async_reset", {tl, tr}, 6'b000_000);
    q.delete();
    @(negedge clk);
    chk("reset_held", {tl, tr}, 6'b000_000);
    rst = 1'b0;
    prefill();
    step("ar_c", 1, 0, 0, 3'b001, 3'b000);
    step("ar_d", 1, 0, 0, 3'b011, 3'b000);
    step("ar_e", 0, 0, 0, 3'b111, 3'b000);
    step("ar_f", 0, 0, 0, 3'b000, 3'b000);

    // 6: STEP_CYCLES=3, L held from release: each pattern lasts 3 cycles
    for (int unsigned i = 0; i < 2; i++) q3.push_back(6'b000_000);
    for (int unsigned i = 0; i < 3; i++) q3.push_back(6'b001_000);
    for (int unsigned i = 0; i < 3; i++) q3.push_back(6'b011_000);
    for (int unsigned i = 0; i < 3; i++) q3.push_back(6'b111_000);
    for (int unsigned i = 0; i < 3; i++) q3.push_back(6'b000_000);
    q3.push_back(6'b001_000);
    rst3 = 1'b0;
    l3   = 1'b1;
    for (int unsigned i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      e3 = q3.pop_front();
      chk($sformatf("slow_%0d", i), {tl3, tr3}, e3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
